// File: rtl/mux_2to1.sv
// Two-input mux with a zero-latency output, an enable-gated registered copy,
// a registered select and a saturating count of select transitions.
module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] y_q,
    output logic             s_q,
    output logic [CNT_W-1:0] sel_changes
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sel_toggled;

    // NOTE: Y is fully assigned on every path, so no latch can be inferred.
    always_comb begin
        Y = S ? B : A;
    end

    // s_q holds S from the previous edge, so this flags a transition at this edge.
    assign sel_toggled = (S != s_q);

    // NOTE: registers use non-blocking assignments and an async reset; the
    // reset branch comes first so it overrides en and any concurrent edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            s_q         <= 1'b0;
            sel_changes <= '0;
        end else begin
            s_q <= S;
            if (en) begin
                y_q <= Y;
            end
            if (sel_toggled && (sel_changes != CNT_MAX)) begin
                sel_changes <= sel_changes + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: a WIDTH=1/CNT_W=2 instance and a
// WIDTH=8/CNT_W=8 instance, with a scoreboard for the wide instance's registers.
module tb_mux_2to1;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic y;
    } vec_t;

    typedef struct {
        logic [7:0] yq;
        logic       sq;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, s1, en1;
    logic       y1, y1_q, s1_q;
    logic [1:0] cnt1;

    logic [7:0] a8, b8;
    logic       s8, en8;
    logic [7:0] y8, y8_q;
    logic       s8_q;
    logic [7:0] cnt8;

    int checks   = 0;
    int failures = 0;

    // reference model of the wide instance's registers
    logic [7:0] m_yq  = 8'h00;
    logic       m_sq  = 1'b0;
    logic [7:0] m_cnt = 8'h00;
    exp_t       sb[$];

    mux_2to1 #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .S(s1), .en(en1),
        .Y(y1), .y_q(y1_q), .s_q(s1_q), .sel_changes(cnt1)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .S(s8), .en(en8),
        .Y(y8), .y_q(y8_q), .s_q(s8_q), .sel_changes(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_yq  = 8'h00;
        m_sq  = 1'b0;
        m_cnt = 8'h00;
    endtask

    // Predict the wide instance's registers for the coming edge, then compare after it.
    task automatic tick();
        exp_t e;
        if (en8) m_yq = s8 ? b8 : a8;
        if ((s8 != m_sq) && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
        m_sq = s8;
        e = '{yq: m_yq, sq: m_sq, cnt: m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("y8_q", y8_q, e.yq);
            check("s8_q", s8_q, e.sq);
            check("cnt8", cnt8, e.cnt);
        end
    endtask

    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic en);
        a8 = a; b8 = b; s8 = s; en8 = en;
        #1;
        check("y8_comb", y8, s ? b : a);
        tick();
    endtask

    initial begin
        vec_t vecs[8];
        logic [1:0] cnt_exp[5];
        logic [7:0] cnt_before;

        vecs[0] = '{a: 0, b: 0, s: 0, y: 0};
        vecs[1] = '{a: 0, b: 1, s: 0, y: 0};
        vecs[2] = '{a: 1, b: 0, s: 0, y: 1};
        vecs[3] = '{a: 1, b: 1, s: 0, y: 1};
        vecs[4] = '{a: 0, b: 0, s: 1, y: 0};
        vecs[5] = '{a: 0, b: 1, s: 1, y: 1};
        vecs[6] = '{a: 1, b: 0, s: 1, y: 0};
        vecs[7] = '{a: 1, b: 1, s: 1, y: 1};
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        a1 = 0; b1 = 0; s1 = 0; en1 = 0;
        a8 = 8'h00; b8 = 8'h00; s8 = 0; en8 = 0;
        #8;
        check("rst_y1_q", y1_q, 0);
        check("rst_s1_q", s1_q, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_y8_q", y8_q, 0);
        check("rst_s8_q", s8_q, 0);
        check("rst_cnt8", cnt8, 0);
        #4;
        rst_n = 1'b1;

        // exhaustive truth table on the 1-bit instance, each vector held one period
        en1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = vecs[i].a; b1 = vecs[i].b; s1 = vecs[i].s;
            #1;
            check("tt_y1", y1, vecs[i].y);
            tick();
            check("tt_y1_q", y1_q, vecs[i].y);
        end

        // wide data, registered copy follows one edge later
        step8(8'hA5, 8'h3C, 1'b0, 1'b1);
        check("wide_yq_a", y8_q, 8'hA5);
        step8(8'hA5, 8'h3C, 1'b1, 1'b1);
        check("wide_yq_b", y8_q, 8'h3C);

        // enable hold: Y tracks inputs, y_q holds until en returns
        step8(8'hA5, 8'h3C, 1'b0, 1'b1);
        step8(8'h5A, 8'h3C, 1'b1, 1'b0);
        check("hold_yq", y8_q, 8'hA5);
        step8(8'h5A, 8'h3C, 1'b1, 1'b0);
        check("hold_yq2", y8_q, 8'hA5);
        step8(8'h5A, 8'h3C, 1'b1, 1'b1);
        check("reload_yq", y8_q, 8'h3C);

        // clean reset, then build y_q=3C, s_q=1, sel_changes=5
        rst_n = 1'b0;
        s1 = 1'b0; s8 = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        step8(8'hA5, 8'h3C, 1'b1, 1'b1);
        step8(8'hA5, 8'h3C, 1'b0, 1'b1);
        step8(8'hA5, 8'h3C, 1'b1, 1'b1);
        step8(8'hA5, 8'h3C, 1'b0, 1'b1);
        step8(8'hA5, 8'h3C, 1'b1, 1'b1);
        check("pre_rst_yq", y8_q, 8'h3C);
        check("pre_rst_sq", s8_q, 1'b1);
        check("pre_rst_cnt", cnt8, 8'd5);

        // asynchronous reset pulse between edges
        #2;
        rst_n = 1'b0;
        s1 = 1'b0;
        #1;
        check("async_rst_yq", y8_q, 8'h00);
        check("async_rst_sq", s8_q, 1'b0);
        check("async_rst_cnt", cnt8, 8'h00);
        check("async_rst_y", y8, 8'h3C);
        #1;
        rst_n = 1'b1;
        model_reset();

        // 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            s1 = ~s1;
            tick();
            check("sat_cnt1", cnt1, cnt_exp[i]);
        end

        // select toggles with en=1 at the same edge
        step8(8'h00, 8'h01, 1'b0, 1'b1);
        cnt_before = cnt8;
        step8(8'h00, 8'h01, 1'b1, 1'b1);
        check("simul_yq", y8_q, 8'h01);
        check("simul_cnt", cnt8, cnt_before + 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
